// File: rtl/regfile_pkg.sv
// Shared constants and types for the 32-entry register file and its read muxes.
package regfile_pkg;

   localparam int DATA_W   = 64;
   localparam int NUM_REGS = 32;
   localparam int ADDR_W   = 5;
   localparam int XZR_IDX  = 31;

   typedef logic [ADDR_W-1:0] reg_addr_t;
   typedef logic [DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/dec5to32.sv
// 5-to-32 one-hot address decoder with enable; all outputs low when disabled.
module dec5to32 (
   input  logic        en,
   input  logic [4:0]  a,
   output logic [31:0] y
);

   always_comb begin
      y = '0;
      if (en) begin
         y[a] = 1'b1;
      end
   end

endmodule

// File: rtl/regfile_rdmux32.sv
// 32:1 read multiplexer for one register-file read port; the zero register reads as 0.
module regfile_rdmux32
   import regfile_pkg::*;
#(
   parameter int DATA_W  = regfile_pkg::DATA_W,
   parameter int XZR_IDX = regfile_pkg::XZR_IDX
) (
   input  logic [DATA_W-1:0] regs_i [NUM_REGS],
   input  reg_addr_t         sel,
   output logic [DATA_W-1:0] data_o
);

   localparam reg_addr_t XZR_ADDR = reg_addr_t'(XZR_IDX);

   always_comb begin
      data_o = regs_i[sel];
      if (sel == XZR_ADDR) begin
         data_o = '0;
      end
   end

endmodule

// File: rtl/regfile_dec32.sv
// 32 x DATA_W register file, one write port decoded by dec5to32, two combinational read ports.
// Optional same-cycle write-to-read bypass: define REGFILE_WRITE_BYPASS_EN.
module regfile_dec32
   import regfile_pkg::*;
#(
   parameter int DATA_W  = regfile_pkg::DATA_W,
   parameter int XZR_IDX = regfile_pkg::XZR_IDX
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  reg_addr_t         wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  reg_addr_t         rd_addr1,
   input  reg_addr_t         rd_addr2,
   output logic [DATA_W-1:0] rd_data1,
   output logic [DATA_W-1:0] rd_data2,
   output logic [NUM_REGS-1:0] wr_onehot
);

   localparam logic [NUM_REGS-1:0] XZR_MASK = {{(NUM_REGS-1){1'b0}}, 1'b1} << XZR_IDX;

   logic [DATA_W-1:0]   regs_q [NUM_REGS];
   logic [DATA_W-1:0]   regs_d [NUM_REGS];
   logic                wr_allow_q;
   logic                wr_allow_d;
   logic [NUM_REGS-1:0] wr_commit;
   logic [DATA_W-1:0]   rd_mux1;
   logic [DATA_W-1:0]   rd_mux2;

   dec5to32 u_dec (
      .en (wr_en),
      .a  (wr_addr),
      .y  (wr_onehot)
   );

   // Writes are suppressed for the first cycle after reset release.
   always_comb begin
      wr_allow_d = 1'b1;
      wr_commit  = wr_onehot & ~XZR_MASK & {NUM_REGS{wr_allow_q}};
      regs_d     = regs_q;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (wr_commit[i]) begin
            regs_d[i] = wr_data;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
         wr_allow_q <= 1'b0;
      end else begin
         regs_q     <= regs_d;
         wr_allow_q <= wr_allow_d;
      end
   end

   regfile_rdmux32 #(.DATA_W(DATA_W), .XZR_IDX(XZR_IDX)) u_rdmux1 (
      .regs_i (regs_q),
      .sel    (rd_addr1),
      .data_o (rd_mux1)
   );

   regfile_rdmux32 #(.DATA_W(DATA_W), .XZR_IDX(XZR_IDX)) u_rdmux2 (
      .regs_i (regs_q),
      .sel    (rd_addr2),
      .data_o (rd_mux2)
   );

`ifdef REGFILE_WRITE_BYPASS_EN
   // Bypass follows the commit condition so reads match what the edge will store.
   always_comb begin
      rd_data1 = rd_mux1;
      rd_data2 = rd_mux2;
      if (wr_commit != '0 && rd_addr1 == wr_addr) begin
         rd_data1 = wr_data;
      end
      if (wr_commit != '0 && rd_addr2 == wr_addr) begin
         rd_data2 = wr_data;
      end
   end
`else
   assign rd_data1 = rd_mux1;
   assign rd_data2 = rd_mux2;
`endif

endmodule

// File: tb/tb_regfile_dec32.sv
// Bench for regfile_dec32: directed vectors, expected values queued and checked by a monitor.
module tb_regfile_dec32;

   logic        clk;
   logic        rst_n;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [63:0] wr_data;
   logic [4:0]  rd_addr1;
   logic [4:0]  rd_addr2;
   logic [63:0] rd_data1;
   logic [63:0] rd_data2;
   logic [31:0] wr_onehot;

   regfile_dec32 dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .rd_addr1  (rd_addr1),
      .rd_addr2  (rd_addr2),
      .rd_data1  (rd_data1),
      .rd_data2  (rd_data2),
      .wr_onehot (wr_onehot)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // scoreboard: kind 0 = rd_data1, 1 = rd_data2, 2 = wr_onehot
   logic [63:0] exp_q[$];
   int          kind_q[$];
   string       tag_q[$];
   int          checks   = 0;
   int          failures = 0;
   event        obs_ev;

   task automatic expect_out(input int kind, input logic [63:0] val, input string tag);
      exp_q.push_back(val);
      kind_q.push_back(kind);
      tag_q.push_back(tag);
   endtask

   task automatic observe();
      -> obs_ev;
      #1;
   endtask

   initial begin : monitor
      logic [63:0] act;
      logic [63:0] exp_v;
      int          k;
      string       t;
      forever begin
         @(obs_ev);
         while (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            k     = kind_q.pop_front();
            t     = tag_q.pop_front();
            case (k)
               0:       act = rd_data1;
               1:       act = rd_data2;
               default: act = {32'h0, wr_onehot};
            endcase
            checks++;
            if (act !== exp_v) begin
               failures++;
               $display("FAIL %s: got %h expected %h", t, act, exp_v);
            end
         end
      end
   end

   // driver tasks
   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
   endtask

   task automatic write_reg(input logic [4:0] a, input logic [63:0] d);
      @(negedge clk);
      wr_en   = 1'b1;
      wr_addr = a;
      wr_data = d;
      @(negedge clk);
      wr_en   = 1'b0;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "bench timeout");
   end

   initial begin : stimulus
      rst_n    = 1'b0;
      wr_en    = 1'b0;
      wr_addr  = '0;
      wr_data  = '0;
      rd_addr1 = '0;
      rd_addr2 = '0;
      wait_cycles(2);
      @(negedge clk);
      rd_addr1 = 5'd4;
      rd_addr2 = 5'd17;
      #1;
      expect_out(0, 64'h0, "reset_rd1");
      expect_out(1, 64'h0, "reset_rd2");
      expect_out(2, 64'h0, "reset_onehot");
      observe();
      rst_n = 1'b1;
      wait_cycles(2);

      // async reset clears a written register without a clock edge
      write_reg(5'd5, 64'hDEAD_BEEF);
      rd_addr1 = 5'd5;
      #1;
      expect_out(0, 64'hDEAD_BEEF, "pre_reset_x5");
      observe();
      #1;
      rst_n = 1'b0;
      #1;
      expect_out(0, 64'h0, "async_reset_x5");
      observe();
      for (int i = 0; i < 32; i++) begin
         rd_addr1 = 5'(i);
         rd_addr2 = 5'(31 - i);
         #1;
         expect_out(0, 64'h0, $sformatf("reset_all_rd1_%0d", i));
         expect_out(1, 64'h0, $sformatf("reset_all_rd2_%0d", 31 - i));
         observe();
      end
      @(negedge clk);
      rst_n = 1'b1;
      wait_cycles(2);

      // basic write/read with onehot during the write cycle
      @(negedge clk);
      wr_en   = 1'b1;
      wr_addr = 5'd7;
      wr_data = 64'h0123_4567_89AB_CDEF;
      #1;
      expect_out(2, 64'h0000_0080, "onehot_x7");
      observe();
      @(negedge clk);
      wr_en    = 1'b0;
      rd_addr1 = 5'd7;
      rd_addr2 = 5'd7;
      #1;
      expect_out(0, 64'h0123_4567_89AB_CDEF, "x7_rd1");
      expect_out(1, 64'h0123_4567_89AB_CDEF, "x7_rd2");
      observe();

      // zero register: onehot asserts but the write is dropped
      write_reg(5'd3, 64'h11);
      @(negedge clk);
      wr_en   = 1'b1;
      wr_addr = 5'd31;
      wr_data = 64'hFFFF_FFFF_FFFF_FFFF;
      rd_addr1 = 5'd31;
      #1;
      expect_out(2, 64'h8000_0000, "onehot_x31");
      observe();
      @(negedge clk);
      wr_en    = 1'b0;
      rd_addr2 = 5'd3;
      #1;
      expect_out(0, 64'h0, "xzr_reads_zero");
      expect_out(1, 64'h11, "x3_untouched_by_xzr");
      observe();
      rd_addr2 = 5'd7;
      #1;
      expect_out(1, 64'h0123_4567_89AB_CDEF, "x7_untouched_by_xzr");
      observe();

      // wr_en low: no decode, no write
      @(negedge clk);
      wr_en   = 1'b0;
      wr_addr = 5'd3;
      wr_data = 64'h55;
      rd_addr1 = 5'd3;
      #1;
      expect_out(2, 64'h0, "onehot_disabled");
      observe();
      @(negedge clk);
      #1;
      expect_out(0, 64'h11, "x3_holds");
      observe();

      // same-cycle read of the register being written
      write_reg(5'd9, 64'hAA);
      @(negedge clk);
      wr_en    = 1'b1;
      wr_addr  = 5'd9;
      wr_data  = 64'hBB;
      rd_addr1 = 5'd9;
      rd_addr2 = 5'd9;
      #1;
`ifdef REGFILE_WRITE_BYPASS_EN
      expect_out(0, 64'hBB, "same_cycle_rd1");
      expect_out(1, 64'hBB, "same_cycle_rd2");
`else
      expect_out(0, 64'hAA, "same_cycle_rd1");
      expect_out(1, 64'hAA, "same_cycle_rd2");
`endif
      observe();
      @(negedge clk);
      wr_en = 1'b0;
      #1;
      expect_out(0, 64'hBB, "after_edge_x9");
      observe();

      // sweep: Xi = i*0x1001 on consecutive cycles, then read pairs (i, 30-i)
      for (int i = 0; i < 31; i++) begin
         @(negedge clk);
         wr_en   = 1'b1;
         wr_addr = 5'(i);
         wr_data = 64'(i) * 64'h1001;
      end
      @(negedge clk);
      wr_en = 1'b0;
      for (int i = 0; i < 31; i++) begin
         rd_addr1 = 5'(i);
         rd_addr2 = 5'(30 - i);
         #1;
         expect_out(0, 64'(i) * 64'h1001, $sformatf("sweep_rd1_%0d", i));
         expect_out(1, 64'(30 - i) * 64'h1001, $sformatf("sweep_rd2_%0d", 30 - i));
         observe();
      end
      rd_addr1 = 5'd31;
      rd_addr2 = 5'd31;
      #1;
      expect_out(0, 64'h0, "sweep_xzr_rd1");
      expect_out(1, 64'h0, "sweep_xzr_rd2");
      observe();

      // final report
      #2;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
